// File: rtl/linescanner_defs.sv
// Shared definitions for the linescanner line path.
// Holds the default pixel width and line length used by both the capture unit
// and the line buffer, the write/read FSM state encodings, and a small helper
// used by the read pipeline to count occupied stages.
package linescanner_defs;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_LINE_PIXELS = 1024;
  localparam int DEF_CNT_WIDTH   = 16;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_CAPTURE = 2'd1,
    W_DROP    = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE     = 2'd0,
    R_PREFETCH = 2'd1,
    R_STREAM   = 2'd2
  } r_state_e;

  // Number of set flags among three single-bit stage valids.
  function automatic logic [1:0] occupancy(input logic a, input logic b, input logic c);
    return {1'b0, a} + {1'b0, b} + {1'b0, c};
  endfunction

endpackage

// File: rtl/linescanner_line_ram.sv
// Simple dual-port line RAM: one write port, one registered read port.
// Depth is 2**ADDR_WIDTH; the line buffer uses the address MSB as bank select.
// No reset on the array or the read register so it maps onto block RAM.
// Ports:
//   clk    in  write and read clock
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  write data
//   raddr  in  read address, sampled every cycle
//   rdata  out data at raddr, one cycle after raddr is presented
module linescanner_line_ram
  import linescanner_defs::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata <= mem_q[raddr];
  end

endmodule

// File: rtl/linescanner_line_buffer.sv
// Line buffer behind the linescanner capture unit.
// Pixels qualified by lval are written into one of two ping-pong banks; each
// completed line is replayed from its bank as a valid/ready stream with
// first/last markers. Banks strictly alternate so lines leave in arrival order.
// Ports:
//   main_clock, n_reset      clock (posedge) and asynchronous active-low reset
//   enable                   gates the start of new lines only
//   pixel_data, lval         capture-side pixel and line-valid
//   out_data/valid/ready     output stream; out_first/out_last mark line ends
//   line_count               lines fully streamed out (wraps)
//   drop_count               lines dropped because no bank was free (saturates)
//   truncated                sticky, a line was longer than LINE_PIXELS
//   w_state_dbg, r_state_dbg current write/read FSM states
//
// Output handshake: a pixel transfers on a clock edge where out_valid and
// out_ready are both 1. Once out_valid is raised, out_data/out_first/out_last
// hold steady and out_valid stays high until that transfer happens; out_valid
// never depends combinationally on out_ready.
module linescanner_line_buffer
  import linescanner_defs::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int LINE_PIXELS = DEF_LINE_PIXELS,
  parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
  input  logic                  main_clock,
  input  logic                  n_reset,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] pixel_data,
  input  logic                  lval,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_first,
  output logic                  out_last,
  output logic [CNT_WIDTH-1:0]  line_count,
  output logic [CNT_WIDTH-1:0]  drop_count,
  output logic                  truncated,
  output w_state_e              w_state_dbg,
  output r_state_e              r_state_dbg
);

  localparam int ADDR_WIDTH = $clog2(LINE_PIXELS);
  localparam int LEN_WIDTH  = ADDR_WIDTH + 1;
  localparam logic [LEN_WIDTH-1:0] LINE_MAX = LEN_WIDTH'(LINE_PIXELS);
  localparam logic [LEN_WIDTH-1:0] LEN_ONE  = LEN_WIDTH'(1);

  // ---------------- state ----------------
  w_state_e              w_state_q, w_state_d;
  r_state_e              r_state_q, r_state_d;
  logic                  lval_prev_q;
  logic                  wr_bank_q, wr_bank_d;
  logic [LEN_WIDTH-1:0]  wr_cnt_q, wr_cnt_d;
  logic [1:0]            full_q, full_d;
  logic [LEN_WIDTH-1:0]  len_q [2];
  logic [LEN_WIDTH-1:0]  len_d [2];
  logic                  rd_bank_q, rd_bank_d;
  logic [LEN_WIDTH-1:0]  rd_idx_q, rd_idx_d;
  logic [CNT_WIDTH-1:0]  line_count_q, line_count_d;
  logic [CNT_WIDTH-1:0]  drop_count_q, drop_count_d;
  logic                  truncated_q, truncated_d;

  // Read pipeline: RAM output stage, output register, skid register.
  logic                  ram_vld_q, ram_first_q, ram_last_q;
  logic                  out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_first_q, out_first_d, out_last_q, out_last_d;
  logic                  skid_vld_q, skid_vld_d;
  logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
  logic                  skid_first_q, skid_first_d, skid_last_q, skid_last_d;

  // ---------------- combinational nets ----------------
  logic                  lval_rise;
  logic                  ram_we;
  logic [ADDR_WIDTH:0]   ram_waddr;
  logic [ADDR_WIDTH:0]   ram_raddr;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  line_done;
  logic                  xfer;
  logic                  rd_release;
  logic                  room;
  logic                  issue;
  logic                  issue_bank;
  logic [LEN_WIDTH-1:0]  issue_idx;
  logic                  issue_first, issue_last;

  // lval_prev_q resets high so a line already in progress at reset release
  // produces no rise and is ignored until lval falls.
  assign lval_rise  = lval & ~lval_prev_q;
  assign xfer       = out_vld_q & out_ready;
  assign rd_release = (r_state_q == R_STREAM) & xfer & out_last_q;
  // Room for one more read once in-flight and held pixels are counted,
  // crediting the slot freed by a transfer this cycle.
  assign room = (occupancy(out_vld_q, skid_vld_q, ram_vld_q) - {1'b0, xfer}) < 2'd2;

  // ---------------- registers ----------------
  always_ff @(posedge main_clock or negedge n_reset) begin
    if (!n_reset) begin
      w_state_q    <= W_IDLE;
      r_state_q    <= R_IDLE;
      lval_prev_q  <= 1'b1;
      wr_bank_q    <= 1'b0;
      wr_cnt_q     <= '0;
      full_q       <= '0;
      len_q[0]     <= '0;
      len_q[1]     <= '0;
      rd_bank_q    <= 1'b0;
      rd_idx_q     <= '0;
      line_count_q <= '0;
      drop_count_q <= '0;
      truncated_q  <= 1'b0;
      ram_vld_q    <= 1'b0;
      ram_first_q  <= 1'b0;
      ram_last_q   <= 1'b0;
      out_vld_q    <= 1'b0;
      out_data_q   <= '0;
      out_first_q  <= 1'b0;
      out_last_q   <= 1'b0;
      skid_vld_q   <= 1'b0;
      skid_data_q  <= '0;
      skid_first_q <= 1'b0;
      skid_last_q  <= 1'b0;
    end else begin
      w_state_q    <= w_state_d;
      r_state_q    <= r_state_d;
      lval_prev_q  <= lval;
      wr_bank_q    <= wr_bank_d;
      wr_cnt_q     <= wr_cnt_d;
      full_q       <= full_d;
      len_q[0]     <= len_d[0];
      len_q[1]     <= len_d[1];
      rd_bank_q    <= rd_bank_d;
      rd_idx_q     <= rd_idx_d;
      line_count_q <= line_count_d;
      drop_count_q <= drop_count_d;
      truncated_q  <= truncated_d;
      ram_vld_q    <= issue;
      ram_first_q  <= issue_first;
      ram_last_q   <= issue_last;
      out_vld_q    <= out_vld_d;
      out_data_q   <= out_data_d;
      out_first_q  <= out_first_d;
      out_last_q   <= out_last_d;
      skid_vld_q   <= skid_vld_d;
      skid_data_q  <= skid_data_d;
      skid_first_q <= skid_first_d;
      skid_last_q  <= skid_last_d;
    end
  end

  // ---------------- write FSM: next state ----------------
  always_comb begin
    w_state_d = w_state_q;
    unique case (w_state_q)
      W_IDLE:    if (lval_rise && enable) w_state_d = full_q[wr_bank_q] ? W_DROP : W_CAPTURE;
      W_CAPTURE: if (!lval) w_state_d = W_IDLE;
      W_DROP:    if (!lval) w_state_d = W_IDLE;
      default:   w_state_d = W_IDLE;
    endcase
  end

  // ---------------- write FSM: outputs ----------------
  always_comb begin
    ram_we       = 1'b0;
    ram_waddr    = {wr_bank_q, wr_cnt_q[ADDR_WIDTH-1:0]};
    wr_cnt_d     = wr_cnt_q;
    wr_bank_d    = wr_bank_q;
    line_done    = 1'b0;
    drop_count_d = drop_count_q;
    truncated_d  = truncated_q;
    unique case (w_state_q)
      W_IDLE: begin
        // The rise cycle already carries pixel 0.
        if (lval_rise && enable && !full_q[wr_bank_q]) begin
          ram_we    = 1'b1;
          ram_waddr = {wr_bank_q, {ADDR_WIDTH{1'b0}}};
          wr_cnt_d  = LEN_ONE;
        end
      end
      W_CAPTURE: begin
        if (lval) begin
          if (wr_cnt_q < LINE_MAX) begin
            ram_we   = 1'b1;
            wr_cnt_d = wr_cnt_q + LEN_ONE;
          end else begin
            truncated_d = 1'b1;
          end
        end else begin
          line_done = 1'b1;
          wr_bank_d = ~wr_bank_q;
          wr_cnt_d  = '0;
        end
      end
      W_DROP: begin
        if (!lval && (drop_count_q != {CNT_WIDTH{1'b1}})) drop_count_d = drop_count_q + 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------- bank bookkeeping ----------------
  // Completion and release always target different banks, so both apply.
  always_comb begin
    full_d   = full_q;
    len_d[0] = len_q[0];
    len_d[1] = len_q[1];
    if (line_done) begin
      full_d[wr_bank_q] = 1'b1;
      len_d[wr_bank_q]  = wr_cnt_q;
    end
    if (rd_release) full_d[rd_bank_q] = 1'b0;
  end

  // ---------------- read FSM: next state ----------------
  always_comb begin
    r_state_d = r_state_q;
    unique case (r_state_q)
      R_IDLE:     if (full_q[rd_bank_q]) r_state_d = R_PREFETCH;
      R_PREFETCH: r_state_d = R_STREAM;
      R_STREAM:   if (rd_release) r_state_d = full_q[~rd_bank_q] ? R_PREFETCH : R_IDLE;
      default:    r_state_d = R_IDLE;
    endcase
  end

  // ---------------- read FSM: outputs (RAM read issue) ----------------
  always_comb begin
    issue        = 1'b0;
    issue_bank   = rd_bank_q;
    issue_idx    = rd_idx_q;
    rd_idx_d     = rd_idx_q;
    rd_bank_d    = rd_bank_q;
    line_count_d = line_count_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (full_q[rd_bank_q]) begin
          issue     = 1'b1;
          issue_idx = '0;
          rd_idx_d  = LEN_ONE;
        end
      end
      R_PREFETCH, R_STREAM: begin
        if ((rd_idx_q < len_q[rd_bank_q]) && room) begin
          issue    = 1'b1;
          rd_idx_d = rd_idx_q + LEN_ONE;
        end
        // All reads of the line were issued before its last pixel left, so
        // the release cycle can start the other bank straight away.
        if (rd_release) begin
          line_count_d = line_count_q + 1'b1;
          rd_bank_d    = ~rd_bank_q;
          if (full_q[~rd_bank_q]) begin
            issue      = 1'b1;
            issue_bank = ~rd_bank_q;
            issue_idx  = '0;
            rd_idx_d   = LEN_ONE;
          end else begin
            rd_idx_d = '0;
          end
        end
      end
      default: ;
    endcase
  end

  assign issue_first = (issue_idx == '0);
  assign issue_last  = (issue_idx == (len_q[issue_bank] - LEN_ONE));
  assign ram_raddr   = {issue_bank, issue_idx[ADDR_WIDTH-1:0]};

  // ---------------- output register and skid ----------------
  // RAM data lands one cycle after issue and cannot wait, so if the output
  // register is held it parks in the skid register; the skid drains first.
  always_comb begin
    out_vld_d    = out_vld_q;
    out_data_d   = out_data_q;
    out_first_d  = out_first_q;
    out_last_d   = out_last_q;
    skid_vld_d   = skid_vld_q;
    skid_data_d  = skid_data_q;
    skid_first_d = skid_first_q;
    skid_last_d  = skid_last_q;
    if (!out_vld_q || xfer) begin
      if (skid_vld_q) begin
        out_vld_d    = 1'b1;
        out_data_d   = skid_data_q;
        out_first_d  = skid_first_q;
        out_last_d   = skid_last_q;
        skid_vld_d   = ram_vld_q;
        skid_data_d  = ram_rdata;
        skid_first_d = ram_first_q;
        skid_last_d  = ram_last_q;
      end else if (ram_vld_q) begin
        out_vld_d   = 1'b1;
        out_data_d  = ram_rdata;
        out_first_d = ram_first_q;
        out_last_d  = ram_last_q;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (ram_vld_q) begin
      skid_vld_d   = 1'b1;
      skid_data_d  = ram_rdata;
      skid_first_d = ram_first_q;
      skid_last_d  = ram_last_q;
    end
  end

  linescanner_line_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH + 1)
  ) u_ram (
    .clk   (main_clock),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (pixel_data),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  assign out_data    = out_data_q;
  assign out_valid   = out_vld_q;
  assign out_first   = out_first_q & out_vld_q;
  assign out_last    = out_last_q & out_vld_q;
  assign line_count  = line_count_q;
  assign drop_count  = drop_count_q;
  assign truncated   = truncated_q;
  assign w_state_dbg = w_state_q;
  assign r_state_dbg = r_state_q;

endmodule

// File: tb/tb_linescanner_line_buffer.sv
module tb_linescanner_line_buffer;

  localparam int DW = 8;
  localparam int LP = 16;
  localparam int CW = 16;

  logic          main_clock;
  logic          n_reset;
  logic          enable;
  logic [DW-1:0] pixel_data;
  logic          lval;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_first;
  logic          out_last;
  logic [CW-1:0] line_count;
  logic [CW-1:0] drop_count;
  logic          truncated;
  logic [1:0]    w_state_dbg;
  logic [1:0]    r_state_dbg;

  int check_cnt = 0;
  int pass_cnt  = 0;

  // {first, last, data}
  logic [DW+1:0] exp_q[$];

  logic          prev_stall;
  logic [DW-1:0] prev_data;

  linescanner_line_buffer #(
    .DATA_WIDTH  (DW),
    .LINE_PIXELS (LP),
    .CNT_WIDTH   (CW)
  ) dut (
    .main_clock  (main_clock),
    .n_reset     (n_reset),
    .enable      (enable),
    .pixel_data  (pixel_data),
    .lval        (lval),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_first   (out_first),
    .out_last    (out_last),
    .line_count  (line_count),
    .drop_count  (drop_count),
    .truncated   (truncated),
    .w_state_dbg (w_state_dbg),
    .r_state_dbg (r_state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  initial main_clock = 1'b0;
  always #5 main_clock = ~main_clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- check helper ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge main_clock) begin
    if (!n_reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_xfer", 32'(out_data), 32'hFFFF_FFFF);
        else check("xfer", 32'({out_first, out_last, out_data}), 32'(exp_q.pop_front()));
      end
      prev_stall = out_valid & ~out_ready;
      prev_data  = out_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_line(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) begin
      @(posedge main_clock); #1;
      lval       = 1'b1;
      pixel_data = DW'(base + DW'(i));
    end
    @(posedge main_clock); #1;
    lval       = 1'b0;
    pixel_data = '0;
  endtask

  task automatic push_exp(input int n, input logic [DW-1:0] base);
    int eff;
    eff = (n > LP) ? LP : n;
    for (int i = 0; i < eff; i++)
      exp_q.push_back({(i == 0), (i == eff - 1), DW'(base + DW'(i))});
  endtask

  task automatic drain(input int budget, input bit toggle, input string tag);
    int n;
    n = 0;
    @(posedge main_clock); #1;
    while ((exp_q.size() != 0) && (n < budget)) begin
      if (toggle) out_ready = ~out_ready;
      @(posedge main_clock); #1;
      n++;
    end
    check(tag, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge main_clock);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    prev_stall = 1'b0;
    prev_data  = '0;
    n_reset    = 1'b0;
    enable     = 1'b1;
    lval       = 1'b1;          // line already running across reset release
    pixel_data = 8'hEE;
    out_ready  = 1'b1;

    wait_cycles(3);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_first", 32'(out_first), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_lines", 32'(line_count), 32'd0);
    check("rst_drops", 32'(drop_count), 32'd0);
    check("rst_trunc", 32'(truncated), 32'd0);

    // Mid-line at release: ignored, nothing captured or dropped.
    n_reset = 1'b1;
    wait_cycles(4);
    lval       = 1'b0;
    pixel_data = '0;
    wait_cycles(6);
    check("midline_wstate", 32'(w_state_dbg), 32'd0);
    check("midline_valid", 32'(out_valid), 32'd0);
    check("midline_drops", 32'(drop_count), 32'd0);

    // Test 1: 8-pixel line, ready held high, latency from lval fall.
    push_exp(8, 8'h10);
    send_line(8, 8'h10);
    @(posedge main_clock);      // lval fall sampled: bank full
    @(posedge main_clock);
    @(negedge main_clock);
    check("lat_n1_valid", 32'(out_valid), 32'd0);
    @(posedge main_clock);
    @(negedge main_clock);
    check("lat_n2_valid", 32'(out_valid), 32'd1);
    check("lat_n2_data", 32'(out_data), 32'h10);
    drain(40, 1'b0, "t1_drain");
    check("t1_lines", 32'(line_count), 32'd1);
    check("t1_rstate", 32'(r_state_dbg), 32'd0);

    // Test 2: same line, ready toggling every cycle.
    out_ready = 1'b0;
    push_exp(8, 8'h10);
    send_line(8, 8'h10);
    drain(80, 1'b1, "t2_drain");
    check("t2_lines", 32'(line_count), 32'd2);

    // Test 3: ready low, three lines: two banked, third dropped.
    out_ready = 1'b0;
    push_exp(4, 8'h20);
    push_exp(4, 8'h30);
    send_line(4, 8'h20);
    send_line(4, 8'h30);
    send_line(4, 8'h40);
    wait_cycles(4);
    check("t3_drops", 32'(drop_count), 32'd1);
    check("t3_hold_valid", 32'(out_valid), 32'd1);
    check("t3_hold_data", 32'(out_data), 32'h20);
    check("t3_hold_first", 32'(out_first), 32'd1);
    check("t3_lines_held", 32'(line_count), 32'd2);
    out_ready = 1'b1;
    drain(60, 1'b0, "t3_drain");
    check("t3_lines", 32'(line_count), 32'd4);

    // Test 4: 20-pixel line into 16-pixel banks.
    check("t4_trunc_before", 32'(truncated), 32'd0);
    push_exp(20, 8'h50);
    send_line(20, 8'h50);
    drain(60, 1'b0, "t4_drain");
    check("t4_trunc", 32'(truncated), 32'd1);
    check("t4_lines", 32'(line_count), 32'd5);

    // Test 5: single-pixel line.
    push_exp(1, 8'hA5);
    send_line(1, 8'hA5);
    drain(30, 1'b0, "t5_drain");
    check("t5_lines", 32'(line_count), 32'd6);

    // enable low: no new line accepted, not counted as a drop.
    enable = 1'b0;
    send_line(3, 8'hC0);
    wait_cycles(8);
    check("en_valid", 32'(out_valid), 32'd0);
    check("en_lines", 32'(line_count), 32'd6);
    check("en_drops", 32'(drop_count), 32'd1);
    enable = 1'b1;

    // Test 6: reset mid-stream with a second line banked.
    out_ready = 1'b0;
    push_exp(4, 8'h60);
    send_line(4, 8'h60);
    send_line(4, 8'h70);
    wait_cycles(3);
    out_ready = 1'b1;
    @(posedge main_clock);
    @(posedge main_clock); #1;
    out_ready = 1'b0;
    check("t6_consumed", 32'(exp_q.size()), 32'd2);
    check("t6_mid_data", 32'(out_data), 32'h62);
    n_reset = 1'b0;
    exp_q.delete();
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_lines", 32'(line_count), 32'd0);
    check("t6_rst_drops", 32'(drop_count), 32'd0);
    check("t6_rst_trunc", 32'(truncated), 32'd0);
    wait_cycles(2);
    n_reset   = 1'b1;
    out_ready = 1'b1;
    wait_cycles(2);
    check("t6_after_valid", 32'(out_valid), 32'd0);
    push_exp(8, 8'h80);
    send_line(8, 8'h80);
    drain(40, 1'b0, "t6_drain");
    check("t6_lines", 32'(line_count), 32'd1);

    wait_cycles(3);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
